// File: rtl/sparc_next_pc_if.sv
// Sequencing-stage bundle: instruction/condition/redirect inputs toward the PC
// stage and the architectural PC/nPC state back out.
interface sparc_next_pc_if;
   logic        Advance;
   logic [31:0] IR;
   logic        Cond;
   logic        Jump_Take;
   logic [31:0] Jump_Target;
   logic        Trap_Take;
   logic [31:0] Trap_Vector;
   logic        ET;
   logic [31:0] PC;
   logic [31:0] nPC;
   logic        Annul;
   logic        Branch_Taken;
   logic        Misaligned;
   logic        Halted;

   modport master (
      output Advance, IR, Cond, Jump_Take, Jump_Target, Trap_Take, Trap_Vector, ET,
      input  PC, nPC, Annul, Branch_Taken, Misaligned, Halted
   );

   modport slave (
      input  Advance, IR, Cond, Jump_Take, Jump_Target, Trap_Take, Trap_Vector, ET,
      output PC, nPC, Annul, Branch_Taken, Misaligned, Halted
   );
endinterface

// File: rtl/sparc_next_pc.sv
// SPARC PC/nPC sequencer: delayed branches with annul, CALL, JMPL/RETT redirect,
// trap vectoring and error-mode halt when a trap arrives with traps disabled.
module sparc_next_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic             Clock,
   input logic             Reset_n,
   sparc_next_pc_if.slave  bus
);

   typedef enum logic [1:0] {RUN, ANNUL, ERROR} state_t;

   state_t      state;
   logic [31:0] pcReg;
   logic [31:0] npcReg;
   logic        annulReg;
   logic        takenReg;
   logic        misReg;
   logic        haltReg;

   logic        isBicc;
   logic        isCall;
   logic        isAlways;
   logic        annulBranch;
   logic        jumpAligned;
   logic [31:0] npcPlus4;
   logic [31:0] branchTarget;
   logic [31:0] callTarget;

   // Targets are relative to the PC of the resolving instruction, not nPC.
   assign isBicc       = (bus.IR[31:30] == 2'b00) && (bus.IR[24:22] == 3'b010);
   assign isCall       = (bus.IR[31:30] == 2'b01);
   assign isAlways     = (bus.IR[28:25] == 4'b1000);
   assign annulBranch  = bus.IR[29] && (!bus.Cond || isAlways);
   assign jumpAligned  = (bus.Jump_Target[1:0] == 2'b00);
   assign npcPlus4     = npcReg + 32'd4;
   assign branchTarget = pcReg + {{8{bus.IR[21]}}, bus.IR[21:0], 2'b00};
   assign callTarget   = pcReg + {bus.IR[29:0], 2'b00};

   // Priority: error hold, trap, stall, annulled slot, then normal decode.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= RUN;
         pcReg    <= RESET_PC;
         npcReg   <= RESET_PC + 32'd4;
         annulReg <= 1'b0;
         takenReg <= 1'b0;
         misReg   <= 1'b0;
         haltReg  <= 1'b0;
      end else if (state != ERROR) begin
         takenReg <= 1'b0;
         misReg   <= 1'b0;
         if (bus.Trap_Take) begin
            if (bus.ET) begin
               pcReg    <= bus.Trap_Vector;
               npcReg   <= bus.Trap_Vector + 32'd4;
               annulReg <= 1'b0;
               state    <= RUN;
            end else begin
               haltReg  <= 1'b1;
               state    <= ERROR;
            end
         end else if (bus.Advance) begin
            if (state == ANNUL) begin
               pcReg    <= npcReg;
               npcReg   <= npcPlus4;
               annulReg <= 1'b0;
               state    <= RUN;
            end else if (isBicc) begin
               pcReg    <= npcReg;
               npcReg   <= bus.Cond ? branchTarget : npcPlus4;
               takenReg <= bus.Cond;
               if (annulBranch) begin
                  annulReg <= 1'b1;
                  state    <= ANNUL;
               end
            end else if (isCall) begin
               pcReg    <= npcReg;
               npcReg   <= callTarget;
               takenReg <= 1'b1;
            end else if (bus.Jump_Take) begin
               if (jumpAligned) begin
                  pcReg    <= npcReg;
                  npcReg   <= bus.Jump_Target;
                  takenReg <= 1'b1;
               end else begin
                  misReg   <= 1'b1;
               end
            end else begin
               pcReg    <= npcReg;
               npcReg   <= npcPlus4;
            end
         end
      end
   end

   assign bus.PC           = pcReg;
   assign bus.nPC          = npcReg;
   assign bus.Annul        = annulReg;
   assign bus.Branch_Taken = takenReg;
   assign bus.Misaligned   = misReg;
   assign bus.Halted       = haltReg;

endmodule

// File: tb/tb_sparc_next_pc.sv
// Self-checking bench for sparc_next_pc: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_sparc_next_pc;

   logic Clock;
   logic Reset_n;

   sparc_next_pc_if bus();

   sparc_next_pc dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mPc;
   logic [31:0] mNpc;
   logic        mAnnul;
   logic        mBt;
   logic        mMis;
   logic        mHalt;

   typedef struct {
      string       name;
      logic [31:0] ir;
      logic        cond;
      logic        jt;
      logic [31:0] jtarget;
      logic [31:0] ePc;
      logic [31:0] eNpc;
      logic        eAnnul;
      logic        eBt;
      logic        eMis;
   } vec_t;

   vec_t vecs[12];

   task automatic modelReset();
      mPc    = 32'h0;
      mNpc   = 32'h4;
      mAnnul = 1'b0;
      mBt    = 1'b0;
      mMis   = 1'b0;
      mHalt  = 1'b0;
   endtask

   // Architectural view: where does control go after this instruction completes?
   task automatic modelStep(input logic adv, input logic [31:0] ir, input logic cond,
                            input logic jt, input logic [31:0] jtgt, input logic tt,
                            input logic [31:0] tv, input logic et);
      int          d;
      logic [31:0] w;
      logic [31:0] target;
      if (mHalt) return;
      mBt  = 1'b0;
      mMis = 1'b0;
      if (tt) begin
         if (et) begin
            mPc = tv; mNpc = tv + 32'd4; mAnnul = 1'b0;
         end else begin
            mHalt = 1'b1;
         end
         return;
      end
      if (!adv) return;
      if (mAnnul) begin
         mPc = mNpc; mNpc = mNpc + 32'd4; mAnnul = 1'b0;
         return;
      end
      if (ir[31:30] == 2'b00 && ir[24:22] == 3'b010) begin
         d = int'(ir[21:0]);
         if (ir[21]) d = d - (1 << 22);
         target = mPc + d * 4;
         mPc    = mNpc;
         mNpc   = cond ? target : mNpc + 32'd4;
         mBt    = cond;
         mAnnul = ir[29] && (!cond || ir[28:25] == 4'd8);
      end else if (ir[31:30] == 2'b01) begin
         w      = {2'b00, ir[29:0]};
         target = mPc + w * 4;
         mPc    = mNpc;
         mNpc   = target;
         mBt    = 1'b1;
      end else if (jt) begin
         if (jtgt % 4 == 0) begin
            mPc = mNpc; mNpc = jtgt; mBt = 1'b1;
         end else begin
            mMis = 1'b1;
         end
      end else begin
         mPc = mNpc; mNpc = mNpc + 32'd4;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] ePc, input logic [31:0] eNpc,
                              input logic eA, input logic eBt, input logic eMis, input logic eH);
      compared++;
      if ({bus.PC, bus.nPC, bus.Annul, bus.Branch_Taken, bus.Misaligned, bus.Halted} !==
          {ePc, eNpc, eA, eBt, eMis, eH}) begin
         mismatched++;
         $display("[TB] FAIL %s: got pc=%h npc=%h a=%b bt=%b mis=%b h=%b, expected pc=%h npc=%h a=%b bt=%b mis=%b h=%b",
                  name, bus.PC, bus.nPC, bus.Annul, bus.Branch_Taken, bus.Misaligned, bus.Halted,
                  ePc, eNpc, eA, eBt, eMis, eH);
      end
   endtask

   task automatic applyStimulus(input logic adv, input logic [31:0] ir, input logic cond,
                                input logic jt, input logic [31:0] jtgt, input logic tt,
                                input logic [31:0] tv, input logic et);
      bus.Advance     = adv;
      bus.IR          = ir;
      bus.Cond        = cond;
      bus.Jump_Take   = jt;
      bus.Jump_Target = jtgt;
      bus.Trap_Take   = tt;
      bus.Trap_Vector = tv;
      bus.ET          = et;
      @(posedge Clock);
      #1;
      modelStep(adv, ir, cond, jt, jtgt, tt, tv, et);
   endtask

   task automatic trapTo(input logic [31:0] addr);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, addr, 1'b1);
   endtask

   task automatic holdCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic doReset(input string name);
      Reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput(name, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge Clock);
      Reset_n = 1'b1;
      holdCycle();
   endtask

   localparam logic [31:0] NOP  = 32'h0100_0000;
   localparam logic [31:0] BNE  = 32'h1280_0004;
   localparam logic [31:0] BAA  = 32'h3080_0004;
   localparam logic [31:0] BEA  = 32'h2280_0004;
   localparam logic [31:0] JMPL = 32'h81C3_E008;

   initial begin
      logic [31:0] r;
      logic [31:0] ir;
      logic [31:0] jtgt;
      logic [31:0] tv;
      logic        adv, cond, jt, tt, et;
      int          cat;

      vecs[0]  = '{"nop",          NOP,          1'b0, 1'b0, 32'h0,   32'h104, 32'h108, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"bne taken",    BNE,          1'b1, 1'b0, 32'h0,   32'h104, 32'h110, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{"bne untaken",  BNE,          1'b0, 1'b0, 32'h0,   32'h104, 32'h108, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"ba,a",         BAA,          1'b1, 1'b0, 32'h0,   32'h104, 32'h110, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{"be,a untaken", BEA,          1'b0, 1'b0, 32'h0,   32'h104, 32'h108, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"be,a taken",   BEA,          1'b1, 1'b0, 32'h0,   32'h104, 32'h110, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{"call -4",      32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0,  32'h104, 32'h0FC, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{"ba disp -1",   32'h10BF_FFFF, 1'b1, 1'b0, 32'h0,  32'h104, 32'h0FC, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{"jmpl aligned", JMPL,         1'b0, 1'b1, 32'h200, 32'h104, 32'h200, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{"jmpl misalign", JMPL,        1'b0, 1'b1, 32'h102, 32'h100, 32'h104, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{"bicc over jump", BNE,        1'b0, 1'b1, 32'h200, 32'h104, 32'h108, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{"sethi",        32'h0300_0040, 1'b1, 1'b0, 32'h0,  32'h104, 32'h108, 1'b0, 1'b0, 1'b0};

      Reset_n = 1'b0;
      bus.Advance = 1'b0; bus.IR = 32'h0; bus.Cond = 1'b0; bus.Jump_Take = 1'b0;
      bus.Jump_Target = 32'h0; bus.Trap_Take = 1'b0; bus.Trap_Vector = 32'h0; bus.ET = 1'b1;
      modelReset();
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      checkOutput("reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      Reset_n = 1'b1;

      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("nop 1", 32'h4, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("nop 2", 32'h8, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         trapTo(32'h100);
         applyStimulus(1'b1, vecs[i].ir, vecs[i].cond, vecs[i].jt, vecs[i].jtarget, 1'b0, 32'h0, 1'b1);
         checkOutput(vecs[i].name, vecs[i].ePc, vecs[i].eNpc, vecs[i].eAnnul, vecs[i].eBt, vecs[i].eMis, 1'b0);
      end

      // Annulled delay slot ignores the branch word presented with it.
      trapTo(32'h100);
      applyStimulus(1'b1, BAA, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, BNE, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
      checkOutput("annul slot", 32'h110, 32'h114, 1'b0, 1'b0, 1'b0, 1'b0);
      holdCycle();
      checkOutput("stall hold", 32'h110, 32'h114, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'h100);
      applyStimulus(1'b1, BNE, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      holdCycle();
      checkOutput("taken pulse", 32'h104, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'h100);
      applyStimulus(1'b1, JMPL, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
      holdCycle();
      checkOutput("misalign pulse", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'h100);
      applyStimulus(1'b1, BAA, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
      checkOutput("trap beats ba,a", 32'h80, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'h100);
      applyStimulus(1'b1, BAA, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b1, 32'h240, 1'b1);
      checkOutput("trap in annul", 32'h240, 32'h244, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("after annul trap", 32'h244, 32'h248, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'hFFFF_FFF8);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("wrap 1", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("wrap 2", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

      trapTo(32'h100);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
      checkOutput("error halt", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
      checkOutput("error frozen", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1);
      doReset("reset from error");

      for (int n = 0; n < 600; n++) begin
         r    = $urandom();
         cat  = $urandom_range(0, 9);
         cond = r[0];
         jt   = r[1];
         adv  = ($urandom_range(0, 9) < 8);
         tt   = ($urandom_range(0, 19) == 0);
         et   = ($urandom_range(0, 9) < 8);
         jtgt = $urandom();
         if ($urandom_range(0, 3) != 0) jtgt[1:0] = 2'b00;
         tv   = $urandom();
         tv[1:0] = 2'b00;
         ir   = $urandom();
         if (cat < 4) begin
            ir[31:30] = 2'b00;
            ir[24:22] = 3'b010;
            if (r[2]) ir[21:0] = r[2] ? {{14{r[3]}}, ir[7:0]} : ir[21:0];
         end else if (cat == 4) begin
            ir[31:30] = 2'b01;
         end else if (cat == 5) begin
            ir[31:30] = 2'b00;
            ir[24:22] = 3'b100;
         end else begin
            ir[31] = 1'b1;
         end
         applyStimulus(adv, ir, cond, jt, jtgt, tt, tv, et);
         checkOutput("random", mPc, mNpc, mAnnul, mBt, mMis, mHalt);
         if (mHalt && $urandom_range(0, 2) == 0) doReset("random reset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
